maxpool2x2_stream: RTL



---
 rtl/maxpool2x2_stream_pkg.sv | 22 ++
 rtl/maxpool2x2_stream_pool_max2.sv | 27 ++
 rtl/maxpool2x2_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/maxpool2x2_stream_pkg.sv
// Shared counter type and wrap helper for the 2x2 max-pool stage.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package maxpool2x2_stream_pkg;

    // Width of the column, line and pooled-index counters and position tags.
    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] cnt_t;

    // Advance a counter by one, returning to zero after its last value.
    function automatic cnt_t cnt_wrap_inc(input cnt_t cnt, input cnt_t last);
        cnt_t nxt;
        if (cnt == last) begin
            nxt = '0;
        end else begin
            nxt = cnt + cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_pool_max2.sv
// Two-input maximum, either signed (two's complement) or unsigned compare.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, output follows inputs.
module pool_max2 #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic a_gt_b;

    // Pick the compare flavour once at elaboration; ties fall through to b,
    // which is the same value, so there is no ordering dependence.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_gt_b = ($signed(a) > $signed(b));
        end else begin : g_unsigned
            assign a_gt_b = (a > b);
        end
    endgenerate

    assign y = a_gt_b ? a : b;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pool fed by a 2-row line buffer; emits one tagged pixel per window.
// Latency: result registered 1 clk after the beat carrying the window's second column.
// Backpressure: none; the consumer must take every valid_out pulse.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COL_NUM = 10,
    parameter int ROW_NUM = 10,
    parameter int SIGNED  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din_r0,
    input  logic [WIDTH-1:0] din_r1,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    output logic [10:0]      out_col,
    output logic [10:0]      out_row,
    output logic             frame_done
);

    localparam int OUT_COL   = COL_NUM / 2;
    localparam int OUT_ROW   = ROW_NUM / 2;
    localparam int LINE_LAST = ROW_NUM - 2;

    localparam cnt_t COL_LAST_C     = cnt_t'(COL_NUM - 1);
    localparam cnt_t LINE_LAST_C    = cnt_t'(LINE_LAST);
    localparam cnt_t OUT_COL_LAST_C = cnt_t'(OUT_COL - 1);
    localparam cnt_t OUT_ROW_LAST_C = cnt_t'(OUT_ROW - 1);

    // Position counters within the window-valid stream.
    cnt_t col_cnt_q,  col_cnt_d;
    cnt_t line_cnt_q, line_cnt_d;

    // Column max of the first (even) column of the current window.
    logic [WIDTH-1:0] hold_q, hold_d;

    // Registered outputs.
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_out_q, valid_out_d;
    cnt_t             out_col_q, out_col_d;
    cnt_t             out_row_q, out_row_d;
    logic             frame_done_q, frame_done_d;

    // Datapath.
    logic [WIDTH-1:0] colmax;
    logic [WIDTH-1:0] hold_r0_max;
    logic [WIDTH-1:0] win_max;

    // Beat qualifiers.
    logic pool_line;
    logic col_odd;
    logic load_hold;
    logic emit;
    logic last_col;
    logic last_window;

    // Vertical max of the two rows for the column currently on the inputs.
    pool_max2 #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_col_max (
        .a (din_r0),
        .b (din_r1),
        .y (colmax)
    );

    // Window max folded as max(max(hold, r0), r1): the same result as
    // max(hold, colmax) but keeps the column-max compare off the emit path.
    pool_max2 #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_win_max_a (
        .a (hold_q),
        .b (din_r0),
        .y (hold_r0_max)
    );

    pool_max2 #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_win_max_b (
        .a (hold_r0_max),
        .b (din_r1),
        .y (win_max)
    );

    // Only even lines pair up rows (0,1), (2,3), ...; odd lines are the
    // overlapping pairs produced by the line buffer and are skipped.
    assign pool_line = ~line_cnt_q[0];
    assign col_odd   = col_cnt_q[0];
    assign last_col  = (col_cnt_q == COL_LAST_C);
    assign load_hold = valid_in & pool_line & ~col_odd;
    assign emit      = valid_in & pool_line & col_odd;

    // The final window of a frame is the last odd column on the last pool line.
    assign last_window = ((col_cnt_q >> 1) == OUT_COL_LAST_C) &&
                         ((line_cnt_q >> 1) == OUT_ROW_LAST_C);

    // Column and line counters advance on every valid beat, wrapping per frame.
    always_comb begin
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        if (valid_in) begin
            col_cnt_d = cnt_wrap_inc(col_cnt_q, COL_LAST_C);
            if (last_col) begin
                line_cnt_d = cnt_wrap_inc(line_cnt_q, LINE_LAST_C);
            end
        end
    end

    // Capture the even column's max; on the odd column, launch the pooled result.
    always_comb begin
        hold_d       = hold_q;
        dout_d       = dout_q;
        valid_out_d  = 1'b0;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        frame_done_d = 1'b0;
        if (load_hold) begin
            hold_d = colmax;
        end
        if (emit) begin
            dout_d       = win_max;
            valid_out_d  = 1'b1;
            out_col_d    = col_cnt_q >> 1;
            out_row_d    = line_cnt_q >> 1;
            frame_done_d = last_window;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            line_cnt_q   <= '0;
            hold_q       <= '0;
            dout_q       <= '0;
            valid_out_q  <= 1'b0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            line_cnt_q   <= line_cnt_d;
            hold_q       <= hold_d;
            dout_q       <= dout_d;
            valid_out_q  <= valid_out_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign valid_out  = valid_out_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;

endmodule
